// File: rtl/smg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
`timescale 1ns/1ps
package smg_pkg;

  localparam int unsigned SEG_W = 8;

  // Active-high patterns, g..a in bits 6..0, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;
  localparam logic [SEG_W-1:0] SEG_DP  = 8'h80;

  typedef enum logic {
    GUARD_PH = 1'b0,
    DRIVE_PH = 1'b1
  } phase_e;

endpackage

// File: rtl/smg_hex7.sv
// Nibble to active-high seven-segment pattern (g..a).
`timescale 1ns/1ps
module smg_hex7
  import smg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered display word.
// Optional feature: SMG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
`timescale 1ns/1ps
module smg_scan_driver
  import smg_pkg::*;
#(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned GUARD          = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [SEG_W-1:0]      seg_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_done
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam phase_e            PHASE_RST = (GUARD != 0) ? GUARD_PH : DRIVE_PH;

  phase_e             phase_q, phase_nxt;
  logic [DIV_W-1:0]   div_q, div_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic               tick_c, frame_start_c, guard_nxt_c;

  logic [DATA_W-1:0]  pend_data, act_data, eff_data;
  logic [DIGITS-1:0]  pend_dp, act_dp, eff_dp;
  logic [DIGITS-1:0]  pend_blank, act_blank, eff_blank;
  logic [DIGITS-1:0]  lz_blank, dark_mask;
  logic               dirty_q;

  logic [3:0]         nib_c;
  logic [6:0]         hex_c;
  logic [SEG_W-1:0]   seg_c;
  logic [DIGITS-1:0]  sel_c;

  assign tick_c        = (div_q == DIV_LAST);
  assign frame_start_c = (div_q == '0) && (idx_q == '0);
  assign div_nxt       = tick_c ? '0 : div_q + DIV_W'(1);
  assign idx_nxt       = !tick_c ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1));

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_nxt_c = 1'b0;
    end else begin : g_guard
      assign guard_nxt_c = (div_nxt < DIV_W'(GUARD));
    end
  endgenerate

  // A frame start with a pending load shows the new word in that same cycle.
  assign eff_data  = (frame_start_c && dirty_q) ? pend_data  : act_data;
  assign eff_dp    = (frame_start_c && dirty_q) ? pend_dp    : act_dp;
  assign eff_blank = (frame_start_c && dirty_q) ? pend_blank : act_blank;

`ifdef SMG_LEADING_ZERO_BLANK_EN
  logic lz_seen;
  always_comb begin
    lz_blank = '0;
    lz_seen  = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (eff_data[4*i +: 4] != 4'h0 || eff_dp[i]) lz_seen = 1'b1;
      lz_blank[i] = !lz_seen;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign dark_mask = eff_blank | lz_blank;
  assign nib_c     = eff_data[{idx_q, 2'b00} +: 4];

  smg_hex7 u_hex7 (
    .nibble (nib_c),
    .seg_c  (hex_c)
  );

  always_ff @(posedge clk) begin
    if (rst) phase_q <= PHASE_RST;
    else     phase_q <= phase_nxt;
  end

  // Slot phase tracks the divider; outputs decode the current slot.
  always_comb begin
    phase_nxt = phase_q;
    seg_c     = SEG_OFF;
    sel_c     = '0;
    phase_nxt = guard_nxt_c ? GUARD_PH : DRIVE_PH;
    if (phase_q == DRIVE_PH) begin
      sel_c = DIGITS'(1) << idx_q;
      if (!dark_mask[idx_q]) seg_c = {1'b0, hex_c} | (eff_dp[idx_q] ? SEG_DP : SEG_OFF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      dirty_q    <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      seg_out    <= SEG_IDLE;
      sel_out    <= SEL_IDLE;
      frame_done <= 1'b0;
    end else begin
      div_q <= div_nxt;
      idx_q <= idx_nxt;
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        dirty_q    <= 1'b1;
      end else if (frame_start_c) begin
        dirty_q    <= 1'b0;
      end
      if (frame_start_c && dirty_q) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      seg_out    <= (SEG_ACTIVE_LOW != 0) ? ~seg_c : seg_c;
      sel_out    <= (SEL_ACTIVE_LOW != 0) ? ~sel_c : sel_c;
      frame_done <= tick_c && (idx_q == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed self-checking bench for smg_scan_driver (4 digits, 4-cycle slots, 1 guard cycle).
`timescale 1ns/1ps
module tb_smg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [7:0]  seg_out;
  logic [3:0]  sel_out;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

`ifdef SMG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  smg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .GUARD(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg_out(seg_out), .sel_out(sel_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Edges since reset release; output after edge n shows slot position n-1.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic wait_pos(input int d, input int v);
    bit found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(posedge clk); #1;
      if (cyc > 0 && ((cyc - 1) % 4) == v && (((cyc - 1) / 4) % 4) == d) found = 1'b1;
    end
    if (!found) begin
      errors++; checks++;
      $display("FAIL wait_pos d%0d v%0d: position never reached", d, v);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got seg=%h sel=%h fd=%b want seg=ff sel=f fd=0", seg_out, sel_out, frame_done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 4'hF) begin
      errors++;
      $display("FAIL reset_first_guard: got seg=%h sel=%h want seg=ff sel=f", seg_out, sel_out);
    end
    @(posedge clk); #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 4'hE) begin
      errors++;
      $display("FAIL reset_first_drive: got seg=%h sel=%h want seg=ff sel=e", seg_out, sel_out);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_seg [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    logic [3:0] exp_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    wait_pos(2, 0);
    do_load(16'h12AF, 4'h0, 4'h0);
    for (int d = 0; d < 4; d++) begin
      wait_pos(d, 0);
      checks++;
      if (seg_out !== 8'hFF || sel_out !== 4'hF) begin
        errors++;
        $display("FAIL guard d%0d: got seg=%h sel=%h want seg=ff sel=f", d, seg_out, sel_out);
      end
      for (int v = 1; v < 4; v++) begin
        wait_pos(d, v);
        checks++;
        if (seg_out !== exp_seg[d] || sel_out !== exp_sel[d]) begin
          errors++;
          $display("FAIL basic d%0d v%0d: got seg=%h sel=%h want seg=%h sel=%h",
                   d, v, seg_out, sel_out, exp_seg[d], exp_sel[d]);
        end
      end
    end
  endtask

  task automatic test_frame_done;
    bit exp;
    for (int n = 0; n < 32; n++) begin
      @(posedge clk); #1;
      exp = (cyc > 0) && (((cyc - 1) % 16) == 15);
      checks++;
      if (frame_done !== exp) begin
        errors++;
        $display("FAIL frame_done cyc%0d: got %b want %b", cyc, frame_done, exp);
      end
    end
  endtask

  task automatic check_digit(input string name, input int d, input logic [7:0] es);
    logic [3:0] esel;
    esel = ~(4'(1) << d);
    wait_pos(d, 1);
    checks++;
    if (seg_out !== es || sel_out !== esel) begin
      errors++;
      $display("FAIL %s d%0d: got seg=%h sel=%h want seg=%h sel=%h", name, d, seg_out, sel_out, es, esel);
    end
  endtask

  task automatic test_double_buffer;
    wait_pos(2, 0);
    do_load(16'h1111, 4'h0, 4'h0);
    wait_pos(1, 0);
    do_load(16'h2222, 4'h0, 4'h0);
    check_digit("dbuf_old", 2, 8'hF9);
    check_digit("dbuf_old", 3, 8'hF9);
    for (int d = 0; d < 4; d++) check_digit("dbuf_new", d, 8'hA4);
  endtask

  task automatic test_back_to_back;
    wait_pos(3, 3);
    do_load(16'h3333, 4'h0, 4'h0);
    check_digit("coincident_old", 0, 8'hA4);
    check_digit("coincident_old", 3, 8'hA4);
    check_digit("coincident_new", 0, 8'hB0);
  endtask

  task automatic test_dp_blank;
    wait_pos(2, 0);
    do_load(16'h8888, 4'b0010, 4'b0100);
    check_digit("dp_blank", 0, 8'h80);
    check_digit("dp_blank", 1, 8'h00);
    check_digit("dp_blank", 2, 8'hFF);
    check_digit("dp_blank", 3, 8'h80);
  endtask

  task automatic test_leading_zero;
    logic [7:0] lzs;
    lzs = LZ ? 8'hFF : 8'hC0;
    wait_pos(2, 0);
    do_load(16'h0070, 4'h0, 4'h0);
    check_digit("lz_0070", 0, 8'hC0);
    check_digit("lz_0070", 1, 8'hF8);
    check_digit("lz_0070", 2, lzs);
    check_digit("lz_0070", 3, lzs);
    wait_pos(2, 0);
    do_load(16'h0000, 4'h0, 4'h0);
    check_digit("lz_0000", 0, 8'hC0);
    check_digit("lz_0000", 1, lzs);
    check_digit("lz_0000", 2, lzs);
    check_digit("lz_0000", 3, lzs);
  endtask

  task automatic test_reset_mid_frame;
    bit seen_fd = 1'b0;
    wait_pos(2, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got seg=%h sel=%h fd=%b want seg=ff sel=f fd=0", seg_out, sel_out, frame_done);
    end
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (frame_done !== 1'b0) seen_fd = 1'b1;
    end
    checks++;
    if (seen_fd) begin
      errors++;
      $display("FAIL midreset_no_frame_done: got pulse want none");
    end
    rst = 1'b0;
    for (int d = 0; d < 4; d++) check_digit("midreset_blank", d, 8'hFF);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_frame_done;
    test_double_buffer;
    test_back_to_back;
    test_dp_blank;
    test_leading_zero;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
